// File: rtl/rptr_empty_lvl_pkg.sv
// Shared FIFO package: pointer-code conversions and default geometry used by
// both the read-side and write-side pointer blocks.
package rptr_empty_lvl_pkg;

  localparam int DEFAULT_ASIZE     = 4;
  localparam int DEFAULT_AE_THRESH = 1;

  // Conversions work on a fixed wide word; callers size-cast in and out.
  localparam int GW = 32;

  function automatic logic [GW-1:0] bin_to_gray(input logic [GW-1:0] b);
    return (b >> 1) ^ b;
  endfunction

  function automatic logic [GW-1:0] gray_to_bin(input logic [GW-1:0] g);
    logic [GW-1:0] b;
    for (int i = 0; i < GW; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/rptr_empty_gray2bin.sv
// Combinational Gray-to-binary converter (XOR prefix from the MSB down).
module gray2bin
  import rptr_empty_lvl_pkg::*;
#(
  parameter int W = DEFAULT_ASIZE + 1
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  always_comb begin
    bin = W'(gray_to_bin(GW'(gray)));
  end

endmodule

// File: rtl/rptr_empty_lvl.sv
// Read-side FIFO pointer block: Gray read pointer, empty / almost-empty flags,
// read-side occupancy and a sticky underflow flag.
module rptr_empty_lvl
  import rptr_empty_lvl_pkg::*;
#(
  parameter int ASIZE     = DEFAULT_ASIZE,
  parameter int AE_THRESH = DEFAULT_AE_THRESH
) (
  input  logic             rclk,
  input  logic             rst_n,
  input  logic [ASIZE:0]   rq2_wptr,
  input  logic             rinc,
  output logic [ASIZE:0]   rptr,
  output logic [ASIZE-1:0] raddr,
  output logic             rempty,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   rlevel,
  output logic             rerr
);

  localparam int PW = ASIZE + 1;

  logic [ASIZE:0] rbin;
  logic [ASIZE:0] rbinnext;
  logic [ASIZE:0] rgraynext;
  logic [ASIZE:0] wbin_s;
  logic [ASIZE:0] level_next;
  logic           rd_en;
  logic           rempty_val;
  logic           ralmost_empty_val;

  gray2bin #(.W(PW)) u_wptr_g2b (
    .gray (rq2_wptr),
    .bin  (wbin_s)
  );

  // A read request while empty never moves the pointer.
  always_comb begin
    rd_en             = rinc & ~rempty;
    rbinnext          = rbin + PW'(rd_en);
    rgraynext         = PW'(bin_to_gray(GW'(rbinnext)));
    rempty_val        = (rgraynext == rq2_wptr);
    level_next        = wbin_s - rbinnext;
    ralmost_empty_val = (level_next <= PW'(AE_THRESH));
  end

  assign raddr = rbin[ASIZE-1:0];

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      rbin          <= '0;
      rptr          <= '0;
      rempty        <= 1'b1;
      ralmost_empty <= 1'b1;
      rlevel        <= '0;
      rerr          <= 1'b0;
    end else begin
      rbin          <= rbinnext;
      rptr          <= rgraynext;
      rempty        <= rempty_val;
      ralmost_empty <= ralmost_empty_val;
      rlevel        <= level_next;
      rerr          <= rerr | (rinc & rempty);
    end
  end

endmodule

// File: tb/tb_rptr_empty_lvl.sv
// Bench for rptr_empty_lvl: directed scenarios plus randomized traffic checked
// against a counter-based occupancy model.
module tb_rptr_empty_lvl;

  localparam int ASIZE = 4;
  localparam int AE    = 1;
  localparam int MOD   = 32;

  logic       rclk;
  logic       rst_n;
  logic [4:0] rq2_wptr;
  logic       rinc;
  logic [4:0] rptr;
  logic [3:0] raddr;
  logic       rempty;
  logic       ralmost_empty;
  logic [4:0] rlevel;
  logic       rerr;

  int checks = 0;
  int errors = 0;

  // Reference model: write and read counts, flags derived from their difference.
  int m_w, m_r, m_level;
  bit m_empty, m_ae, m_err;

  rptr_empty_lvl #(.ASIZE(ASIZE), .AE_THRESH(AE)) dut (
    .rclk          (rclk),
    .rst_n         (rst_n),
    .rq2_wptr      (rq2_wptr),
    .rinc          (rinc),
    .rptr          (rptr),
    .raddr         (raddr),
    .rempty        (rempty),
    .ralmost_empty (ralmost_empty),
    .rlevel        (rlevel),
    .rerr          (rerr)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  function automatic logic [4:0] to_gray(input int v);
    int g;
    g = (v ^ (v >> 1)) & (MOD - 1);
    return g[4:0];
  endfunction

  task automatic model_reset();
    m_w = 0; m_r = 0; m_level = 0;
    m_empty = 1; m_ae = 1; m_err = 0;
  endtask

  // Apply inputs, take one rising edge, advance the model, settle past the edge.
  task automatic drive(input bit ri, input int w);
    rinc     = ri;
    m_w      = w & (MOD - 1);
    rq2_wptr = to_gray(m_w);
    @(posedge rclk);
    if (ri && m_empty) m_err = 1;
    else if (ri) m_r = (m_r + 1) % MOD;
    m_level = (m_w - m_r + MOD) % MOD;
    m_empty = (m_level == 0);
    m_ae    = (m_level <= AE);
    #1;
  endtask

  task automatic do_reset();
    rinc = 0; rq2_wptr = '0;
    @(negedge rclk);
    rst_n = 0;
    model_reset();
    @(negedge rclk);
    @(negedge rclk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    drive(0, 3);
    drive(1, 3);
    checks++;
    if (rptr !== 5'd1 || rempty !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset_state: rptr=%b rempty=%b required rptr=00001 rempty=0", rptr, rempty);
    end
    @(negedge rclk);
    #2;
    rst_n = 0;
    model_reset();
    #1;
    checks++;
    if (rptr !== 5'd0 || raddr !== 4'd0) begin
      errors++;
      $display("FAIL reset_ptr: rptr=%b raddr=%0d required 0/0", rptr, raddr);
    end
    checks++;
    if (rempty !== 1'b1 || ralmost_empty !== 1'b1 || rlevel !== 5'd0 || rerr !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: rempty=%b ae=%b rlevel=%0d rerr=%b required 1/1/0/0",
               rempty, ralmost_empty, rlevel, rerr);
    end
    rq2_wptr = '0; rinc = 0;
    @(negedge rclk);
    rst_n = 1;
    drive(0, 0);
    checks++;
    if (rempty !== 1'b1) begin
      errors++;
      $display("FAIL release_empty: rempty=%b required 1", rempty);
    end
  endtask

  task automatic test_fill_drain();
    logic [3:0] exp_addr [3] = '{4'd1, 4'd2, 4'd3};
    logic [4:0] exp_lvl  [3] = '{5'd2, 5'd1, 5'd0};
    logic       exp_ae   [3] = '{1'b0, 1'b1, 1'b1};
    logic       exp_emp  [3] = '{1'b0, 1'b0, 1'b1};
    do_reset();
    drive(0, 3);
    checks++;
    if (rempty !== 1'b0 || rlevel !== 5'd3 || ralmost_empty !== 1'b0) begin
      errors++;
      $display("FAIL fill: rempty=%b rlevel=%0d ae=%b required 0/3/0", rempty, rlevel, ralmost_empty);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 3);
      checks++;
      if (raddr !== exp_addr[i] || rlevel !== exp_lvl[i] ||
          ralmost_empty !== exp_ae[i] || rempty !== exp_emp[i]) begin
        errors++;
        $display("FAIL drain_%0d: raddr=%0d rlevel=%0d ae=%b rempty=%b required %0d/%0d/%b/%b",
                 i, raddr, rlevel, ralmost_empty, rempty, exp_addr[i], exp_lvl[i], exp_ae[i], exp_emp[i]);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    drive(0, 16);
    checks++;
    if (rlevel !== 5'd16 || rempty !== 1'b0 || ralmost_empty !== 1'b0) begin
      errors++;
      $display("FAIL wrap_full: rlevel=%0d rempty=%b ae=%b required 16/0/0", rlevel, rempty, ralmost_empty);
    end
    for (int i = 0; i < 16; i++) begin
      drive(1, 16);
      checks++;
      if (raddr !== 4'((i + 1) % 16)) begin
        errors++;
        $display("FAIL wrap_addr_%0d: raddr=%0d required %0d", i, raddr, (i + 1) % 16);
      end
    end
    checks++;
    if (rptr !== 5'b11000 || rempty !== 1'b1 || rlevel !== 5'd0 || rerr !== 1'b0) begin
      errors++;
      $display("FAIL wrap_end: rptr=%b rempty=%b rlevel=%0d rerr=%b required 11000/1/0/0",
               rptr, rempty, rlevel, rerr);
    end
  endtask

  task automatic test_underflow();
    drive(1, 16);
    checks++;
    if (rptr !== 5'b11000 || raddr !== 4'd0 || rerr !== 1'b1) begin
      errors++;
      $display("FAIL underflow: rptr=%b raddr=%0d rerr=%b required 11000/0/1", rptr, raddr, rerr);
    end
    drive(0, 18);
    drive(1, 18);
    drive(1, 18);
    checks++;
    if (rerr !== 1'b1 || rempty !== 1'b1 || raddr !== 4'd2) begin
      errors++;
      $display("FAIL err_sticky: rerr=%b rempty=%b raddr=%0d required 1/1/2", rerr, rempty, raddr);
    end
    do_reset();
    #1;
    checks++;
    if (rerr !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: rerr=%b required 0", rerr);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    drive(0, 1);
    checks++;
    if (rlevel !== 5'd1 || ralmost_empty !== 1'b1) begin
      errors++;
      $display("FAIL simul_pre: rlevel=%0d ae=%b required 1/1", rlevel, ralmost_empty);
    end
    drive(1, 2);
    checks++;
    if (rlevel !== 5'd1 || rempty !== 1'b0 || raddr !== 4'd1) begin
      errors++;
      $display("FAIL simul: rlevel=%0d rempty=%b raddr=%0d required 1/0/1", rlevel, rempty, raddr);
    end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    drive(0, 7);
    drive(1, 7);
    drive(1, 7);
    checks++;
    if (rlevel !== 5'd5) begin
      errors++;
      $display("FAIL middrain_level: rlevel=%0d required 5", rlevel);
    end
    rinc = 1;
    #2;
    rst_n = 0;
    model_reset();
    #1;
    checks++;
    if (rptr !== 5'd0 || raddr !== 4'd0 || rempty !== 1'b1 || ralmost_empty !== 1'b1 ||
        rlevel !== 5'd0 || rerr !== 1'b0) begin
      errors++;
      $display("FAIL middrain_reset: rptr=%b raddr=%0d rempty=%b ae=%b rlevel=%0d rerr=%b",
               rptr, raddr, rempty, ralmost_empty, rlevel, rerr);
    end
    @(posedge rclk);
    #1;
    checks++;
    if (rptr !== 5'd0 || rlevel !== 5'd0 || rempty !== 1'b1) begin
      errors++;
      $display("FAIL reset_hold: rptr=%b rlevel=%0d rempty=%b required 0/0/1", rptr, rlevel, rempty);
    end
    rinc = 0; rq2_wptr = '0;
    @(negedge rclk);
    rst_n = 1;
    drive(0, 0);
    checks++;
    if (rempty !== 1'b1 || rptr !== 5'd0 || rlevel !== 5'd0) begin
      errors++;
      $display("FAIL middrain_release: rempty=%b rptr=%b rlevel=%0d required 1/0/0", rempty, rptr, rlevel);
    end
  endtask

  task automatic test_random();
    int w;
    bit ri;
    do_reset();
    w = 0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 99) < 50 && ((w - m_r + MOD) % MOD) < 16) w = (w + 1) % MOD;
      ri = ($urandom_range(0, 99) < 45);
      drive(ri, w);
      checks++;
      if (rptr !== to_gray(m_r) || raddr !== 4'(m_r % 16) || rempty !== m_empty ||
          ralmost_empty !== m_ae || rlevel !== 5'(m_level) || rerr !== m_err) begin
        errors++;
        $display("FAIL random_%0d: rptr=%b raddr=%0d rempty=%b ae=%b rlevel=%0d rerr=%b required %b/%0d/%b/%b/%0d/%b",
                 i, rptr, raddr, rempty, ralmost_empty, rlevel, rerr,
                 to_gray(m_r), m_r % 16, m_empty, m_ae, m_level, m_err);
      end
    end
  endtask

  initial begin
    rst_n = 0; rinc = 0; rq2_wptr = '0;
    model_reset();
    test_reset();
    test_fill_drain();
    test_wrap();
    test_underflow();
    test_simultaneous();
    test_reset_mid_drain();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rptr_empty_lvl.md
RPTR_EMPTY_LVL -- requirements
Module: rptr_empty_lvl

Interface
REQ-001 SHALL have parameter ASIZE, default 4, meaning FIFO address width; depth is 2^ASIZE.
REQ-002 SHALL have parameter AE_THRESH, default 1, meaning the almost-empty threshold in entries, range 0..2^ASIZE-1.
REQ-003 SHALL have port rclk, input, 1 bit: the read-domain clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: the reset; asynchronous and active-low.
REQ-005 SHALL have port rq2_wptr, input, ASIZE+1 bits: the Gray-coded write pointer, already double-synchronized into rclk.
REQ-006 SHALL have port rinc, input, 1 bit: read request for the current cycle.
REQ-007 SHALL have port rptr, output, ASIZE+1 bits: the registered Gray-coded read pointer, sent to the write domain.
REQ-008 SHALL have port raddr, output, ASIZE bits: the memory read address.
REQ-009 SHALL have port rempty, output, 1 bit: registered FIFO-empty flag.
REQ-010 SHALL have port ralmost_empty, output, 1 bit: registered flag, high when the occupancy is at or below AE_THRESH.
REQ-011 SHALL have port rlevel, output, ASIZE+1 bits: registered occupancy as seen from the read side, range 0..2^ASIZE.
REQ-012 SHALL have port rerr, output, 1 bit: sticky underflow flag.

Function
REQ-013 SHALL hold a binary read pointer rbin of ASIZE+1 bits; raddr = rbin[ASIZE-1:0], driven combinationally from the register.
REQ-014 SHALL compute rbinnext = rbin + (rinc AND NOT rempty), using modulo-2^(ASIZE+1) wrap.
REQ-015 SHALL compute rgraynext = (rbinnext >> 1) XOR rbinnext, and register rbinnext into rbin and rgraynext into rptr on every rclk edge.
REQ-016 SHALL register rempty_val = (rgraynext == rq2_wptr) into rempty; the flag has one-cycle latency from the pointer update.
REQ-017 SHALL convert rq2_wptr from Gray to binary (wbin_s) combinationally and register rlevel = (wbin_s - rbinnext) mod 2^(ASIZE+1).
REQ-018 SHALL register ralmost_empty = ((wbin_s - rbinnext) <= AE_THRESH); ralmost_empty is high whenever rempty is high.
REQ-019 SHALL ignore rinc while rempty=1: rbin, rptr and raddr stay unchanged and rerr is set to 1.
REQ-020 SHALL keep rerr at 1 until reset; no other event clears it.
REQ-021 SHALL, on rinc in the same cycle as an rq2_wptr change, use both the new rq2_wptr and the incremented rbinnext for rempty, rlevel and ralmost_empty.
REQ-022 SHALL wrap raddr from 2^ASIZE-1 to 0, and SHALL toggle the MSB of rptr every 2^ASIZE reads.
REQ-023 SHALL consider rlevel values above 2^ASIZE unreachable under correct write-side operation; no saturation logic is required.

Reset
REQ-024 SHALL, on rst_n=0, immediately force rbin=0, rptr=0, raddr=0, rempty=1, ralmost_empty=1, rlevel=0 and rerr=0, independent of rclk.
REQ-025 SHALL, on reset mid-operation, discard all read progress; after release the block behaves exactly as after power-up.
REQ-026 SHALL release reset with rempty=1 until the first rclk edge that sees rq2_wptr != 0.

Structure
REQ-027 SHALL place the Gray-to-binary and binary-to-Gray conversion functions, and the default ASIZE and AE_THRESH constants, in the shared FIFO package used by the write side.
REQ-028 SHALL use one sub-module, gray2bin (ASIZE+1 bits wide, combinational XOR prefix), instantiated for rq2_wptr.
REQ-029 SHALL use no memory array; data storage stays in the FIFO top level.

Verification (ASIZE=4, AE_THRESH=1)
REQ-030 SHALL cover reset: assert rst_n=0 mid-clock -> outputs immediately read rptr=0, raddr=0, rempty=1, ralmost_empty=1, rlevel=0, rerr=0.
REQ-031 SHALL cover fill then drain: rq2_wptr=5'b00010 (bin 3), no rinc -> next edge rempty=0, rlevel=3, ralmost_empty=0; then 3 consecutive rinc -> raddr 1,2,3; rlevel 2,1,0; ralmost_empty=1 at level 1; rempty=1 after the third read.
REQ-032 SHALL cover wrap: rq2_wptr=5'b11000 (bin 16), 16 consecutive rinc -> raddr steps 15 to 0, final rptr=5'b11000, rempty=1, rlevel=0, rerr=0.
REQ-033 SHALL cover underflow: rempty=1, pulse rinc -> rptr and raddr unchanged, rerr=1; then write 2 entries and read 2 entries -> rerr stays 1 until rst_n pulse.
REQ-034 SHALL cover simultaneous events: rlevel=1, rinc in the same cycle rq2_wptr advances by 1 -> next edge rlevel=1, rempty=0.
REQ-035 SHALL cover reset mid-drain: rlevel=5, assert rst_n during rinc -> all outputs return to reset values; after release with rq2_wptr=0, rempty=1.
